mem_bus_responder: RTL and testbench
====================================

# mem_bus_responder

Single-outstanding bus responder between the CPU load/store port and the four memory regions: BRAM, SRAM, flash and peripherals. It accepts one CPU request and decodes `addr[31:16]` into a region. It then drives a req/ack handshake to the selected region and returns exactly one acknowledge to the CPU, carrying read data or an error. Errors cover unmapped addresses and slave timeouts, so the CPU never hangs on a dead slave.

## Interface
- `TIMEOUT_CYCLES`, default 16: number of WAIT cycles without a slave ack before an error response (minimum 2).
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  reset, synchronous and active-high.
- `cpu_req`  in  1  request strobe; sampled only in IDLE.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  32  byte address.
- `cpu_wdata`  in  32  write data.
- `cpu_wstrb`  in  4  byte enables.
- `cpu_ack`  out  1  one-cycle response pulse.
- `cpu_rdata`  out  32  read data; valid when `cpu_ack`=1.
- `cpu_err`  out  1  error flag; valid when `cpu_ack`=1.
- `slv_req`  out  4  one-hot request: bit0 BRAM, bit1 SRAM, bit2 flash, bit3 peripheral.
- `slv_we`  out  1  latched `cpu_we`.
- `slv_addr`  out  16  latched `cpu_addr[15:0]` (region offset).
- `slv_wdata`  out  32  latched write data.
- `slv_wstrb`  out  4  latched byte enables.
- `slv_ack`  in  4  per-region acknowledge, one-hot.
- `slv_rdata`  in  128  packed read data; region i is at `[32*i+31:32*i]`.

## Operation
- Region map on `addr[31:16]`: 0x0000 BRAM, 0x0001 SRAM, 0x0002 flash, 0x0003 peripheral. Any other value is unmapped.
- FSM states: IDLE, WAIT, RESP.
- IDLE → WAIT when `cpu_req`=1 and the region is mapped:
  - latch region, `we`, `addr[15:0]`, `wdata`, `wstrb`;
  - clear the timeout counter.
- IDLE → RESP when `cpu_req`=1 and the region is unmapped:
  - set the error flag; read data = 0;
  - no `slv_req` is issued.
- WAIT:
  - `slv_req[region]` is held high; all other `slv_req` bits are 0.
  - If `slv_ack[region]`=1: capture the region's `slv_rdata` (0 for writes), clear error, go to RESP.
  - Else if counter == `TIMEOUT_CYCLES`-1: set error, read data = 0, go to RESP.
  - Else: counter increments by 1.
- RESP:
  - `cpu_ack`=1 for exactly this cycle, with `cpu_rdata`/`cpu_err` from the captured values;
  - `slv_req`=0;
  - next state is IDLE.
- `cpu_req` is ignored in WAIT and RESP. There is no queue; the CPU re-presents after `cpu_ack`.
- Acks from non-selected regions, and any ack in IDLE or RESP, are ignored.
- `slv_*` data outputs hold their latched values until the next accepted request.

## Timing
- Reset values: state IDLE, `cpu_ack`=0, `cpu_err`=0, `cpu_rdata`=0, `slv_req`=0, `slv_we`=0, `slv_addr`=0, `slv_wdata`=0, `slv_wstrb`=0, counter 0.
- All outputs are registered; no combinational path from input to output.
- Let E0 be the acceptance edge.
  - Mapped access: `slv_req` is high from E0.
  - Slave acks in the first WAIT cycle: `cpu_ack` is high in the cycle after E1 (2-cycle latency).
  - Each additional wait cycle adds 1 cycle of latency.
- Unmapped access: `cpu_ack` with `cpu_err`=1 is high in the cycle after E0 (1-cycle latency).
- Timeout: `cpu_ack` with `cpu_err`=1 follows exactly `TIMEOUT_CYCLES` WAIT cycles, then RESP.
- Ack arriving on the timeout cycle: the ack wins and there is no error.
- Back-to-back requests: the earliest next acceptance is the IDLE cycle after RESP.
- Reset mid-WAIT or mid-RESP: in the cycle after the reset edge, `slv_req`=0, `cpu_ack`=0 and the state is IDLE. The in-flight response is dropped.
- Counter width is `$clog2(TIMEOUT_CYCLES)`; the counter never wraps.

## Structure
- Package `mem_map_pkg` holds:
  - region IDs and base constants (0x0000–0x0003);
  - region count (4) and one-hot bit positions;
  - the FSM state enum.
- Sub-module `mem_region_decode`: purely combinational, maps `addr[31:16]` to a 4-bit one-hot region plus an `unmapped` flag. `mem_bus_responder` owns the FSM, counter, latches and read-data mux.

## Test plan
- Read BRAM at 0x0000_0010; the BRAM slave acks in its first WAIT cycle with 0xDEADBEEF.
  - Expect `slv_req`=0001 and `slv_addr`=0x0010.
  - Expect `cpu_ack` 2 cycles after acceptance, `cpu_rdata`=0xDEADBEEF, `cpu_err`=0.
- Write 0x12345678 with `wstrb`=0011 to peripheral 0x0003_0004; the slave acks after 3 wait cycles.
  - Expect `slv_req`=1000, `slv_we`=1, `slv_wstrb`=0011.
  - Expect `cpu_ack` 5 cycles after acceptance, `cpu_rdata`=0.
- Read 0x0005_0000 (unmapped).
  - Expect `slv_req` to stay 0.
  - Expect `cpu_ack` with `cpu_err`=1 and `cpu_rdata`=0 one cycle after acceptance.
- Read flash 0x0002_0000 with no ack and `TIMEOUT_CYCLES`=16.
  - Expect `slv_req`=0100 for 16 cycles.
  - Then expect `cpu_ack` with `cpu_err`=1.
  - Repeat with the ack on the 16th cycle: expect `cpu_err`=0.
- Reading SRAM, drive `slv_ack`=0001 (the wrong region) and then 0010.
  - Expect the BRAM ack to be ignored.
  - Expect the response to use SRAM data.
  - A `cpu_req` pulse held during WAIT must not start a second access.
- Assert `rst` for one cycle mid-WAIT.
  - Expect `slv_req`=0 and state IDLE in the next cycle, with no `cpu_ack`.
  - A new BRAM request after reset completes normally.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Shared memory-map constants and FSM state type for the CPU bus responder.
package mem_map_pkg;

    localparam int NUM_REGIONS = 4;

    // Region IDs double as the one-hot bit position of each region.
    localparam int BIT_BRAM   = 0;
    localparam int BIT_SRAM   = 1;
    localparam int BIT_FLASH  = 2;
    localparam int BIT_PERIPH = 3;

    // Values of addr[31:16] that select each region.
    localparam logic [15:0] BASE_BRAM   = 16'h0000;
    localparam logic [15:0] BASE_SRAM   = 16'h0001;
    localparam logic [15:0] BASE_FLASH  = 16'h0002;
    localparam logic [15:0] BASE_PERIPH = 16'h0003;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_region_decode.sv
// Combinational decode of the upper address half into a one-hot region.
module mem_region_decode
    import mem_map_pkg::*;
(
    input  logic [15:0]            addr_hi,
    output logic [NUM_REGIONS-1:0] region_oh,
    output logic                   unmapped
);

    // One-hot region select; anything outside the four bases is unmapped.
    always_comb begin
        region_oh = '0;
        unmapped  = 1'b0;
        case (addr_hi)
            BASE_BRAM:   region_oh[BIT_BRAM]   = 1'b1;
            BASE_SRAM:   region_oh[BIT_SRAM]   = 1'b1;
            BASE_FLASH:  region_oh[BIT_FLASH]  = 1'b1;
            BASE_PERIPH: region_oh[BIT_PERIPH] = 1'b1;
            default:     unmapped              = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Single-outstanding CPU bus responder with region decode and slave timeout.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for cpu_req; decodes and latches the request
//   WAIT    | slv_req held on the selected region; waiting for ack/timeout
//   RESP    | cpu_ack pulse with captured rdata/err; back to IDLE next
module mem_bus_responder
    import mem_map_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [31:0]               cpu_addr,
    input  logic [31:0]               cpu_wdata,
    input  logic [3:0]                cpu_wstrb,
    output logic                      cpu_ack,
    output logic [31:0]               cpu_rdata,
    output logic                      cpu_err,
    output logic [NUM_REGIONS-1:0]    slv_req,
    output logic                      slv_we,
    output logic [15:0]               slv_addr,
    output logic [31:0]               slv_wdata,
    output logic [3:0]                slv_wstrb,
    input  logic [NUM_REGIONS-1:0]    slv_ack,
    input  logic [32*NUM_REGIONS-1:0] slv_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                   state_q, state_d;
    logic [NUM_REGIONS-1:0]   region_q, region_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     cpu_ack_q, cpu_ack_d;
    logic                     cpu_err_q, cpu_err_d;
    logic [31:0]              cpu_rdata_q, cpu_rdata_d;
    logic [NUM_REGIONS-1:0]   slv_req_q, slv_req_d;
    logic                     slv_we_q, slv_we_d;
    logic [15:0]              slv_addr_q, slv_addr_d;
    logic [31:0]              slv_wdata_q, slv_wdata_d;
    logic [3:0]               slv_wstrb_q, slv_wstrb_d;

    logic [NUM_REGIONS-1:0]   dec_oh;
    logic                     dec_unmapped;
    logic                     ack_hit;
    logic [31:0]              sel_rdata;

    mem_region_decode u_decode (
        .addr_hi   (cpu_addr[31:16]),
        .region_oh (dec_oh),
        .unmapped  (dec_unmapped)
    );

    // Ack and read-data lane of the latched region only; other lanes are ignored.
    always_comb begin
        ack_hit   = |(slv_ack & region_q);
        sel_rdata = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (region_q[i]) begin
                sel_rdata = sel_rdata | slv_rdata[32*i +: 32];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        region_d    = region_q;
        cnt_d       = cnt_q;
        cpu_ack_d   = 1'b0;
        cpu_err_d   = cpu_err_q;
        cpu_rdata_d = cpu_rdata_q;
        slv_req_d   = slv_req_q;
        slv_we_d    = slv_we_q;
        slv_addr_d  = slv_addr_q;
        slv_wdata_d = slv_wdata_q;
        slv_wstrb_d = slv_wstrb_q;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    if (dec_unmapped) begin
                        state_d     = ST_RESP;
                        cpu_ack_d   = 1'b1;
                        cpu_err_d   = 1'b1;
                        cpu_rdata_d = '0;
                    end else begin
                        state_d     = ST_WAIT;
                        region_d    = dec_oh;
                        slv_req_d   = dec_oh;
                        slv_we_d    = cpu_we;
                        slv_addr_d  = cpu_addr[15:0];
                        slv_wdata_d = cpu_wdata;
                        slv_wstrb_d = cpu_wstrb;
                        cnt_d       = '0;
                    end
                end
            end
            ST_WAIT: begin
                // An ack on the final wait cycle still wins over the timeout.
                if (ack_hit) begin
                    state_d     = ST_RESP;
                    slv_req_d   = '0;
                    cpu_ack_d   = 1'b1;
                    cpu_err_d   = 1'b0;
                    cpu_rdata_d = slv_we_q ? 32'h0 : sel_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_RESP;
                    slv_req_d   = '0;
                    cpu_ack_d   = 1'b1;
                    cpu_err_d   = 1'b1;
                    cpu_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                slv_req_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            region_q    <= '0;
            cnt_q       <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            cpu_rdata_q <= '0;
            slv_req_q   <= '0;
            slv_we_q    <= 1'b0;
            slv_addr_q  <= '0;
            slv_wdata_q <= '0;
            slv_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            region_q    <= region_d;
            cnt_q       <= cnt_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_err_q   <= cpu_err_d;
            cpu_rdata_q <= cpu_rdata_d;
            slv_req_q   <= slv_req_d;
            slv_we_q    <= slv_we_d;
            slv_addr_q  <= slv_addr_d;
            slv_wdata_q <= slv_wdata_d;
            slv_wstrb_q <= slv_wstrb_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign cpu_err   = cpu_err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign slv_req   = slv_req_q;
    assign slv_we    = slv_we_q;
    assign slv_addr  = slv_addr_q;
    assign slv_wdata = slv_wdata_q;
    assign slv_wstrb = slv_wstrb_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder; inputs driven and outputs sampled on negedge.
module tb_mem_bus_responder;
    import mem_map_pkg::*;

    logic         clk;
    logic         rst;
    logic         cpu_req;
    logic         cpu_we;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [3:0]   cpu_wstrb;
    logic         cpu_ack;
    logic [31:0]  cpu_rdata;
    logic         cpu_err;
    logic [3:0]   slv_req;
    logic         slv_we;
    logic [15:0]  slv_addr;
    logic [31:0]  slv_wdata;
    logic [3:0]   slv_wstrb;
    logic [3:0]   slv_ack;
    logic [127:0] slv_rdata;

    int total = 0;
    int bad   = 0;

    mem_bus_responder #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wstrb (cpu_wstrb),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .cpu_err   (cpu_err),
        .slv_req   (slv_req),
        .slv_we    (slv_we),
        .slv_addr  (slv_addr),
        .slv_wdata (slv_wdata),
        .slv_wstrb (slv_wstrb),
        .slv_ack   (slv_ack),
        .slv_rdata (slv_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One request; slave ack mask asserted on WAIT cycle ack_cyc (0 = never),
    // a stray ack on wrong_cyc and a stray cpu_req on pulse_cyc.
    task automatic do_access(
        input string       tag,
        input logic        we,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [3:0]  wstrb,
        input int          ack_cyc,
        input logic [3:0]  ack_mask,
        input int          wrong_cyc,
        input logic [3:0]  wrong_mask,
        input int          pulse_cyc,
        input logic [3:0]  exp_req,
        input int          exp_lat,
        input logic        exp_err,
        input logic [31:0] exp_rdata
    );
        int          lat;
        int          req_cnt;
        bit          got;
        logic        o_err;
        logic [31:0] o_rdata;
        lat = 0; req_cnt = 0; got = 0; o_err = 1'bx; o_rdata = 'x;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr;
        cpu_wdata = wdata; cpu_wstrb = wstrb;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk({tag, "_req"}, 32'(slv_req), 32'(exp_req));
                if (exp_req != 4'b0) begin
                    chk({tag, "_we"},    32'(slv_we),    32'(we));
                    chk({tag, "_addr"},  32'(slv_addr),  32'(addr[15:0]));
                    chk({tag, "_wdata"}, slv_wdata,      wdata);
                    chk({tag, "_wstrb"}, 32'(slv_wstrb), 32'(wstrb));
                end
            end
            if (slv_req != 4'b0) req_cnt++;
            if (cpu_ack) begin
                got = 1; lat = k; o_err = cpu_err; o_rdata = cpu_rdata;
            end
            if (k == pulse_cyc) begin
                cpu_req = 1'b1; cpu_addr = 32'h0000_0020;
            end else begin
                cpu_req = 1'b0;
            end
            slv_ack = (k == ack_cyc) ? ack_mask : (k == wrong_cyc) ? wrong_mask : 4'b0;
        end
        cpu_req = 1'b0;
        slv_ack = 4'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_err"}, 32'(o_err), 32'(exp_err));
        chk({tag, "_rdata"}, o_rdata, exp_rdata);
        chk({tag, "_req_cycles"}, 32'(req_cnt), 32'(exp_lat - 1));
        @(negedge clk);
        chk({tag, "_ack_pulse"}, 32'(cpu_ack), 32'h0);
    endtask

    initial begin
        int busy;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
        cpu_wdata = '0; cpu_wstrb = '0; slv_ack = '0; slv_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack",   32'(cpu_ack),   32'h0);
        chk("rst_err",   32'(cpu_err),   32'h0);
        chk("rst_rdata", cpu_rdata,      32'h0);
        chk("rst_req",   32'(slv_req),   32'h0);
        chk("rst_we",    32'(slv_we),    32'h0);
        chk("rst_addr",  32'(slv_addr),  32'h0);
        chk("rst_wdata", slv_wdata,      32'h0);
        chk("rst_wstrb", 32'(slv_wstrb), 32'h0);
        chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        rst = 1'b0;

        slv_rdata = {32'hCCCC_3333, 32'hF1A5_0002, 32'h5A5A_1111, 32'hDEAD_BEEF};

        // tag, we, addr, wdata, wstrb, ack_cyc, mask, wrong_cyc, wmask, pulse, exp_req, lat, err, rdata
        do_access("bram_rd", 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1, 4'b0001, 0, 4'b0, 0,
                  4'b0001, 2, 1'b0, 32'hDEAD_BEEF);
        do_access("periph_wr", 1'b1, 32'h0003_0004, 32'h1234_5678, 4'b0011, 4, 4'b1000, 0, 4'b0, 0,
                  4'b1000, 5, 1'b0, 32'h0);
        do_access("unmapped", 1'b0, 32'h0005_0000, 32'h0, 4'h0, 0, 4'b0, 1, 4'b1111, 0,
                  4'b0000, 1, 1'b1, 32'h0);
        do_access("flash_to", 1'b0, 32'h0002_0000, 32'h0, 4'h0, 0, 4'b0, 0, 4'b0, 0,
                  4'b0100, 17, 1'b1, 32'h0);
        do_access("flash_ack16", 1'b0, 32'h0002_0000, 32'h0, 4'h0, 16, 4'b0100, 0, 4'b0, 0,
                  4'b0100, 17, 1'b0, 32'hF1A5_0002);
        do_access("sram_wrong", 1'b0, 32'h0001_0008, 32'h0, 4'h0, 2, 4'b0010, 1, 4'b0001, 1,
                  4'b0010, 3, 1'b0, 32'h5A5A_1111);

        busy = 0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_ack || slv_req != 4'b0) busy++;
        end
        chk("no_second_access", 32'(busy), 32'h0);

        // Reset during WAIT drops the access.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0002_0100;
        @(negedge clk);
        cpu_req = 1'b0;
        chk("rstmid_req_before", 32'(slv_req), 32'h4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_req",   32'(slv_req),      32'h0);
        chk("rstmid_ack",   32'(cpu_ack),      32'h0);
        chk("rstmid_state", 32'(dut.state_q),  32'(ST_IDLE));
        chk("rstmid_addr",  32'(slv_addr),     32'h0);
        busy = 0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_ack || slv_req != 4'b0) busy++;
        end
        chk("rstmid_quiet", 32'(busy), 32'h0);

        do_access("bram_after_rst", 1'b0, 32'h0000_0044, 32'h0, 4'h0, 1, 4'b0001, 0, 4'b0, 0,
                  4'b0001, 2, 1'b0, 32'hDEAD_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
